// File: rtl/sent_tx_crc_sched.sv
// SENT transmit CRC scheduler: arbitrates fast- and slow-channel CRC requests onto one shared
// CRC generator, checks the generator's done code, aborts on timeout and guards against slow starvation.
module sent_tx_crc_sched #(
    parameter int unsigned TIMEOUT_CYC   = 127,
    parameter int unsigned SLOW_MAX_WAIT = 2
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        fc_req,
    input  logic [1:0]  fc_mode,
    input  logic [23:0] fc_data,
    output logic        fc_ack,
    output logic [3:0]  fc_crc,
    output logic        fc_valid,
    output logic        fc_err,
    input  logic        sc_req,
    input  logic        sc_enh,
    input  logic [23:0] sc_data,
    output logic        sc_ack,
    output logic [5:0]  sc_crc,
    output logic        sc_valid,
    output logic        sc_err,
    output logic [2:0]  enable_crc_gen,
    output logic [23:0] data_gen_crc,
    input  logic [5:0]  crc_gen,
    input  logic [1:0]  crc_gen_done,
    output logic        busy
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned ST_W  = (SLOW_MAX_WAIT < 1) ? 1 : $clog2(SLOW_MAX_WAIT + 1);

    localparam logic [2:0] EN_OFF   = 3'b000;
    localparam logic [2:0] EN_SHORT = 3'b100;
    localparam logic [2:0] EN_ENH   = 3'b101;

    localparam logic [1:0] DONE_FAST  = 2'b01;
    localparam logic [1:0] DONE_SHORT = 2'b10;
    localparam logic [1:0] DONE_ENH   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ST_W-1:0]   r_starve;
    logic              r_is_fast;
    logic              r_illegal;
    logic [2:0]        r_enable;
    logic [23:0]       r_data;
    logic              r_fc_ack;
    logic [3:0]        r_fc_crc;
    logic              r_fc_valid;
    logic              r_fc_err;
    logic              r_sc_ack;
    logic [5:0]        r_sc_crc;
    logic              r_sc_valid;
    logic              r_sc_err;
    logic              r_busy;

    state_t            w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [ST_W-1:0]   w_starve;
    logic              w_is_fast;
    logic              w_illegal;
    logic [2:0]        w_enable;
    logic [23:0]       w_data;
    logic              w_fc_ack;
    logic [3:0]        w_fc_crc;
    logic              w_fc_valid;
    logic              w_fc_err;
    logic              w_sc_ack;
    logic [5:0]        w_sc_crc;
    logic              w_sc_valid;
    logic              w_sc_err;
    logic              w_busy;

    logic              w_slow_wins;
    logic              w_grant_fast;
    logic [1:0]        w_exp_done;
    logic              w_fin;
    logic              w_res_err;
    logic [5:0]        w_res_crc;

    // Slow channel takes the grant once it has been passed over SLOW_MAX_WAIT times.
    assign w_slow_wins  = sc_req && (r_starve == ST_W'(SLOW_MAX_WAIT));
    assign w_grant_fast = fc_req && !w_slow_wins;
    assign w_exp_done   = r_is_fast ? DONE_FAST : ((r_enable == EN_ENH) ? DONE_ENH : DONE_SHORT);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_starve   = r_starve;
        w_is_fast  = r_is_fast;
        w_illegal  = r_illegal;
        w_enable   = r_enable;
        w_data     = r_data;
        w_fc_ack   = 1'b0;
        w_fc_crc   = r_fc_crc;
        w_fc_valid = 1'b0;
        w_fc_err   = 1'b0;
        w_sc_ack   = 1'b0;
        w_sc_crc   = r_sc_crc;
        w_sc_valid = 1'b0;
        w_sc_err   = 1'b0;
        w_fin      = 1'b0;
        w_res_err  = 1'b0;
        w_res_crc  = 6'd0;

        case (r_state)
            ST_IDLE: begin
                w_enable = EN_OFF;
                if (w_grant_fast) begin
                    w_fc_ack  = 1'b1;
                    w_is_fast = 1'b1;
                    w_cnt     = '0;
                    w_state   = ST_WAIT;
                    if (fc_mode == 2'd3) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_illegal = 1'b0;
                        w_enable  = {1'b0, 2'(fc_mode + 2'd1)};
                        w_data    = fc_data;
                    end
                    if (sc_req && (r_starve != ST_W'(SLOW_MAX_WAIT))) begin
                        w_starve = r_starve + ST_W'(1);
                    end
                end else if (sc_req) begin
                    w_sc_ack  = 1'b1;
                    w_is_fast = 1'b0;
                    w_illegal = 1'b0;
                    w_cnt     = '0;
                    w_starve  = '0;
                    w_state   = ST_WAIT;
                    w_enable  = sc_enh ? EN_ENH : EN_SHORT;
                    w_data    = sc_enh ? sc_data : {12'd0, sc_data[11:0]};
                end
            end

            ST_WAIT: begin
                if (r_illegal) begin
                    w_fin     = 1'b1;
                    w_res_err = 1'b1;
                end else if (crc_gen_done != 2'b00) begin
                    w_fin = 1'b1;
                    if (crc_gen_done == w_exp_done) begin
                        w_res_crc = (w_exp_done == DONE_ENH) ? crc_gen : {2'b00, crc_gen[3:0]};
                    end else begin
                        w_res_err = 1'b1;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_fin     = 1'b1;
                    w_res_err = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end

                if (w_fin) begin
                    w_state  = ST_RELEASE;
                    w_cnt    = '0;
                    w_enable = EN_OFF;
                    if (r_is_fast) begin
                        w_fc_valid = 1'b1;
                        w_fc_err   = w_res_err;
                        w_fc_crc   = w_res_crc[3:0];
                    end else begin
                        w_sc_valid = 1'b1;
                        w_sc_err   = w_res_err;
                        w_sc_crc   = w_res_crc;
                    end
                end
            end

            ST_RELEASE: begin
                w_enable = EN_OFF;
                if (r_cnt != '0) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = CNT_W'(1);
                end
            end

            default: begin
                w_state  = ST_IDLE;
                w_cnt    = '0;
                w_enable = EN_OFF;
            end
        endcase

        if (!sc_req) begin
            w_starve = '0;
        end
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_starve   <= '0;
            r_is_fast  <= 1'b0;
            r_illegal  <= 1'b0;
            r_enable   <= EN_OFF;
            r_data     <= 24'd0;
            r_fc_ack   <= 1'b0;
            r_fc_crc   <= 4'd0;
            r_fc_valid <= 1'b0;
            r_fc_err   <= 1'b0;
            r_sc_ack   <= 1'b0;
            r_sc_crc   <= 6'd0;
            r_sc_valid <= 1'b0;
            r_sc_err   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_starve   <= w_starve;
            r_is_fast  <= w_is_fast;
            r_illegal  <= w_illegal;
            r_enable   <= w_enable;
            r_data     <= w_data;
            r_fc_ack   <= w_fc_ack;
            r_fc_crc   <= w_fc_crc;
            r_fc_valid <= w_fc_valid;
            r_fc_err   <= w_fc_err;
            r_sc_ack   <= w_sc_ack;
            r_sc_crc   <= w_sc_crc;
            r_sc_valid <= w_sc_valid;
            r_sc_err   <= w_sc_err;
            r_busy     <= w_busy;
        end
    end

    assign fc_ack         = r_fc_ack;
    assign fc_crc         = r_fc_crc;
    assign fc_valid       = r_fc_valid;
    assign fc_err         = r_fc_err;
    assign sc_ack         = r_sc_ack;
    assign sc_crc         = r_sc_crc;
    assign sc_valid       = r_sc_valid;
    assign sc_err         = r_sc_err;
    assign enable_crc_gen = r_enable;
    assign data_gen_crc   = r_data;
    assign busy           = r_busy;

endmodule
